regfile_read_arbiter: RTL and testbench
=======================================

REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 SHALL have parameter REG_BITS_SIZE, default 5, register address width.
REQ-002 SHALL have parameter INST_SIZE, default 32, register data width.
REQ-003 SHALL have parameter NUM_REQ, default 2, number of requesters; legal range 2..4.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester read request.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-008 SHALL have port req_rs1  input  NUM_REQ*REG_BITS_SIZE  packed source-1 addresses; requester i at slice i.
REQ-009 SHALL have port req_rs2  input  NUM_REQ*REG_BITS_SIZE  packed source-2 addresses.
REQ-010 SHALL have port rsp_valid  output  1  response data valid.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have port rsp_id  output  clog2(NUM_REQ)  index of requester owning the response.
REQ-013 SHALL have ports rsp_val1, rsp_val2  output  INST_SIZE each  operand values.
REQ-014 SHALL have ports rf_rs1, rf_rs2  output  REG_BITS_SIZE each  register file read addresses.
REQ-015 SHALL have ports rf_val1, rf_val2  input  INST_SIZE each  register file read data, valid one cycle after address.
REQ-016 SHALL have ports wr_en (1), wr_rd (REG_BITS_SIZE), wr_data (INST_SIZE), all inputs  writeback snoop.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-018 IDLE: if any req_valid, SHALL grant one requester by round-robin, assert its req_ready combinationally, latch id/rs1/rs2, go ISSUE; else stay.
REQ-019 Round-robin: search starts at pointer ptr; after grant to i, ptr SHALL become (i+1) mod NUM_REQ; ptr unchanged when no grant.
REQ-020 req_ready SHALL be 0 in all states other than IDLE.
REQ-021 ISSUE and CAPTURE: rf_rs1/rf_rs2 SHALL drive latched addresses; in IDLE/RESP they SHALL drive 0.
REQ-022 ISSUE SHALL always go to CAPTURE next cycle; CAPTURE SHALL sample rf_val1/rf_val2 at its ending edge and go RESP.
REQ-023 Latency: accept in cycle T SHALL yield rsp_valid=1 in cycle T+3.
REQ-024 Address 0 SHALL return 0 regardless of rf_val or writes.
REQ-025 Bypass: wr_en=1 with wr_rd!=0 and wr_rd equal to a latched address during ISSUE or CAPTURE SHALL make the captured value wr_data (latest write wins) instead of rf_val.
REQ-026 In RESP, a matching write SHALL update the held rsp_val1/rsp_val2 on the next edge; rsp_valid stays high.
REQ-027 rs1==rs2 SHALL apply bypass to both operands identically.
REQ-028 RESP: rsp_valid=1, rsp_id/rsp_val stable except REQ-026; on rsp_ready=1 SHALL go IDLE next cycle.
REQ-029 A new grant SHALL NOT occur in the cycle rsp_ready is accepted; earliest next accept is the following IDLE cycle.
REQ-030 Requests deasserted before acceptance SHALL be dropped without side effects.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_val1=rsp_val2=0, latched addresses 0, req_ready=0.
REQ-032 Reset mid-transaction SHALL discard it; no response SHALL be produced after reset release.
REQ-033 First cycle after reset release SHALL be able to accept a request.

Verification
REQ-034 Single read: rf holds r3=0x11, r5=0x22; req0 rs1=3, rs2=5 accepted at T -> rsp_valid at T+3, id=0, val1=0x11, val2=0x22.
REQ-035 Contention: req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0.
REQ-036 Bypass: req rs1=7, wr_en wr_rd=7 wr_data=0xDEADBEEF during CAPTURE -> rsp_val1=0xDEADBEEF; same write to rd=0 -> value 0.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles, write to rs2 in RESP with 0xA5 -> rsp_val2 becomes 0xA5, rsp_valid held, no new req_ready.
REQ-038 Reset in CAPTURE -> outputs zero at once; after release no rsp_valid until a new request, first grant to requester 0.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// ============================================================================
// Module   : regfile_read_arbiter
// Purpose  : Round-robin arbiter that shares one register-file read port
//            among several requesters, with writeback bypass on the operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_arbiter #(
  parameter int REG_BITS_SIZE = 5,
  parameter int INST_SIZE     = 32,
  parameter int NUM_REQ       = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*REG_BITS_SIZE-1:0] req_rs1,
  input  logic [NUM_REQ*REG_BITS_SIZE-1:0] req_rs2,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [INST_SIZE-1:0]             rsp_val1,
  output logic [INST_SIZE-1:0]             rsp_val2,
  output logic [REG_BITS_SIZE-1:0]         rf_rs1,
  output logic [REG_BITS_SIZE-1:0]         rf_rs2,
  input  logic [INST_SIZE-1:0]             rf_val1,
  input  logic [INST_SIZE-1:0]             rf_val2,
  input  logic                             wr_en,
  input  logic [REG_BITS_SIZE-1:0]         wr_rd,
  input  logic [INST_SIZE-1:0]             wr_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic [REG_BITS_SIZE-1:0] rs1_q, rs1_d;
  logic [REG_BITS_SIZE-1:0] rs2_q, rs2_d;
  logic [INST_SIZE-1:0]     val1_q, val1_d;
  logic [INST_SIZE-1:0]     val2_q, val2_d;
  logic                     byp1_q, byp1_d;
  logic                     byp2_q, byp2_d;

  logic [REG_BITS_SIZE-1:0] w_rs1_arr [NUM_REQ];
  logic [REG_BITS_SIZE-1:0] w_rs2_arr [NUM_REQ];
  logic                     w_grant;
  logic [ID_W-1:0]          w_grant_id;
  logic [ID_W-1:0]          w_cand;
  int                       w_idx;
  logic                     w_hit1;
  logic                     w_hit2;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_rs1_arr[g] = req_rs1[g*REG_BITS_SIZE +: REG_BITS_SIZE];
    assign w_rs2_arr[g] = req_rs2[g*REG_BITS_SIZE +: REG_BITS_SIZE];
  end

  // Scan requesters starting at ptr_q, wrapping; first valid one wins.
  always_comb begin
    w_grant    = 1'b0;
    w_grant_id = '0;
    w_idx      = 0;
    w_cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(ptr_q) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_cand = ID_W'(w_idx);
      if (!w_grant && req_valid[w_cand]) begin
        w_grant    = 1'b1;
        w_grant_id = w_cand;
      end
    end
  end

  // Writes to r0 never match, so a hit also implies a non-zero operand address.
  assign w_hit1 = wr_en && (wr_rd != '0) && (wr_rd == rs1_q);
  assign w_hit2 = wr_en && (wr_rd != '0) && (wr_rd == rs2_q);

  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && w_grant && !reset) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    byp1_d  = byp1_q;
    byp2_d  = byp2_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant) begin
          state_d = ST_ISSUE;
          id_d    = w_grant_id;
          rs1_d   = w_rs1_arr[w_grant_id];
          rs2_d   = w_rs2_arr[w_grant_id];
          ptr_d   = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
          val1_d  = '0;
          val2_d  = '0;
          byp1_d  = 1'b0;
          byp2_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
        if (w_hit1) begin
          val1_d = wr_data;
          byp1_d = 1'b1;
        end
        if (w_hit2) begin
          val2_d = wr_data;
          byp2_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_RESP;
        // A write in this cycle beats an earlier bypass, which beats the RF.
        if (rs1_q == '0) begin
          val1_d = '0;
        end else if (w_hit1) begin
          val1_d = wr_data;
        end else if (!byp1_q) begin
          val1_d = rf_val1;
        end
        if (rs2_q == '0) begin
          val2_d = '0;
        end else if (w_hit2) begin
          val2_d = wr_data;
        end else if (!byp2_q) begin
          val2_d = rf_val2;
        end
      end
      ST_RESP: begin
        if (w_hit1) begin
          val1_d = wr_data;
        end
        if (w_hit2) begin
          val2_d = wr_data;
        end
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      byp1_q  <= 1'b0;
      byp2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      byp1_q  <= byp1_d;
      byp2_q  <= byp2_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_val1  = val1_q;
  assign rsp_val2  = val2_q;
  assign rf_rs1    = ((state_q == ST_ISSUE) || (state_q == ST_CAPTURE)) ? rs1_q : '0;
  assign rf_rs2    = ((state_q == ST_ISSUE) || (state_q == ST_CAPTURE)) ? rs2_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
// ============================================================================
// Module   : tb_regfile_read_arbiter
// Purpose  : Scoreboard bench for regfile_read_arbiter with a registered RF model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_read_arbiter;

  localparam int RB = 5;
  localparam int IW = 32;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*RB-1:0] req_rs1;
  logic [NR*RB-1:0] req_rs2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [0:0]       rsp_id;
  logic [IW-1:0]    rsp_val1;
  logic [IW-1:0]    rsp_val2;
  logic [RB-1:0]    rf_rs1;
  logic [RB-1:0]    rf_rs2;
  logic [IW-1:0]    rf_val1;
  logic [IW-1:0]    rf_val2;
  logic             wr_en;
  logic [RB-1:0]    wr_rd;
  logic [IW-1:0]    wr_data;

  regfile_read_arbiter #(
    .REG_BITS_SIZE(RB),
    .INST_SIZE    (IW),
    .NUM_REQ      (NR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs1  (req_rs1),
    .req_rs2  (req_rs2),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_val1 (rsp_val1),
    .rsp_val2 (rsp_val2),
    .rf_rs1   (rf_rs1),
    .rf_rs2   (rf_rs2),
    .rf_val1  (rf_val1),
    .rf_val2  (rf_val2),
    .wr_en    (wr_en),
    .wr_rd    (wr_rd),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  // Register file contents are fixed; writes are only snooped by the DUT.
  logic [IW-1:0] rf_mem [32];
  always @(posedge clk) begin
    rf_val1 <= rf_mem[rf_rs1];
    rf_val2 <= rf_mem[rf_rs2];
  end

  typedef struct packed {
    logic [0:0]    id;
    logic [IW-1:0] v1;
    logic [IW-1:0] v2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got response id %0d, expected none", rsp_id);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_val1", 64'(rsp_val1), 64'(mon_e.v1));
        check("rsp_val2", 64'(rsp_val2), 64'(mon_e.v2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [IW-1:0] v1, input logic [IW-1:0] v2);
    exp_t e;
    e.id = 1'(id);
    e.v1 = v1;
    e.v2 = v2;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [RB-1:0] a, input logic [RB-1:0] b);
    req_valid[i]          = 1'b1;
    req_rs1[i*RB +: RB]   = a;
    req_rs2[i*RB +: RB]   = b;
  endtask

  task automatic wait_grant(input logic [NR-1:0] exp, input string name);
    int cyc = 0;
    @(negedge clk);
    while (req_ready == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 64'(req_ready), 64'(exp));
  endtask

  // One full transaction with optional snooped writes during ISSUE and CAPTURE.
  task automatic txn(input int id, input logic [RB-1:0] a, input logic [RB-1:0] b,
                     input logic [IW-1:0] e1, input logic [IW-1:0] e2,
                     input logic iw, input logic [RB-1:0] ird, input logic [IW-1:0] idat,
                     input logic cw, input logic [RB-1:0] crd, input logic [IW-1:0] cdat);
    tick();
    set_req(id, a, b);
    push(id, e1, e2);
    wait_grant(2'(1 << id), "txn_grant");
    tick();
    req_valid[id] = 1'b0;
    wr_en = iw; wr_rd = ird; wr_data = idat;
    tick();
    wr_en = cw; wr_rd = crd; wr_data = cdat;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    check("txn_rsp_valid", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    int ngr;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + i;
    rf_mem[0] = 32'hFFFF_FFFF;
    rf_mem[3] = 32'h11;
    rf_mem[5] = 32'h22;
    reset = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
    req_rs1 = '0; req_rs2 = '0; wr_en = 1'b0; wr_rd = '0; wr_data = '0;

    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_val1", 64'(rsp_val1), 64'd0);
    check("rst_rf_rs1", 64'(rf_rs1), 64'd0);
    req_valid = '0;
    tick();
    reset = 1'b0;

    // Single read with explicit latency checks
    set_req(0, 5'd3, 5'd5);
    push(0, 32'h11, 32'h22);
    @(negedge clk);
    check("first_accept", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("issue_rsp_valid", 64'(rsp_valid), 64'd0);
    check("issue_rf_rs1", 64'(rf_rs1), 64'd3);
    check("issue_rf_rs2", 64'(rf_rs2), 64'd5);
    check("issue_req_ready", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    check("capture_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    check("resp_rf_rs1", 64'(rf_rs1), 64'd0);

    txn(0, 5'd7, 5'd9, 32'hDEAD_BEEF, 32'h109, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    txn(0, 5'd0, 5'd7, 32'h0, 32'h107, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    txn(0, 5'd12, 5'd13, 32'h1111_2222, 32'h3333, 1'b1, 5'd12, 32'h1111_2222, 1'b1, 5'd13, 32'h3333);
    txn(0, 5'd12, 5'd12, 32'hBBBB, 32'hBBBB, 1'b1, 5'd12, 32'hAAAA, 1'b1, 5'd12, 32'hBBBB);
    txn(0, 5'd5, 5'd3, 32'h22, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Backpressure: held response with snooped write to rs2
    tick();
    rsp_ready = 1'b0;
    set_req(1, 5'd3, 5'd20);
    push(1, 32'h11, 32'hA5);
    wait_grant(2'b10, "bp_grant");
    tick();
    req_valid = '0;
    tick();
    tick();
    set_req(0, 5'd3, 5'd5);
    set_req(1, 5'd3, 5'd20);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        wr_en = 1'b1; wr_rd = 5'd20; wr_data = 32'hA5;
      end
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_no_ready", 64'(req_ready), 64'd0);
      if (c == 1) check("bp_val2_before", 64'(rsp_val2), 64'h114);
      if (c == 3) check("bp_val2_after", 64'(rsp_val2), 64'hA5);
      tick();
      wr_en = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("accept_cycle_no_grant", 64'(req_ready), 64'd0);

    // Contention: both requesters held valid
    push(0, 32'h11, 32'h22);
    push(1, 32'h11, 32'h114);
    push(0, 32'h11, 32'h22);
    push(1, 32'h11, 32'h114);
    ngr = 0;
    for (int cyc = 0; cyc < 40 && ngr < 4; cyc++) begin
      tick();
      @(negedge clk);
      if (req_ready != '0) begin
        check("contend_grant", 64'(req_ready), (ngr % 2 == 0) ? 64'b01 : 64'b10);
        ngr++;
      end
    end
    check("contend_grant_count", 64'(ngr), 64'd4);
    tick();
    req_valid = '0;
    for (int cyc = 0; cyc < 10 && sb_q.size() != 0; cyc++) tick();
    check("contend_drain", 64'(sb_q.size()), 64'd0);

    // Reset during CAPTURE, with ptr left pointing at requester 1
    txn(0, 5'd5, 5'd5, 32'h22, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    set_req(0, 5'd3, 5'd5);
    wait_grant(2'b01, "pre_rst_grant");
    tick();
    req_valid = '0;
    wr_en = 1'b1; wr_rd = 5'd3; wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    check("pre_rst_rf_rs1", 64'(rf_rs1), 64'd3);
    req_valid = 2'b11;
    reset = 1'b1;
    #1;
    check("mid_rst_rf_rs1", 64'(rf_rs1), 64'd0);
    check("mid_rst_rsp_val1", 64'(rsp_val1), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = '0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(rsp_valid), 64'd0);
      tick();
    end
    set_req(0, 5'd9, 5'd3);
    set_req(1, 5'd3, 5'd20);
    push(0, 32'h109, 32'h11);
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    tick();
    check("final_drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
